// File: rtl/trinity_pkg.sv
// Shared constants for the trinity tile: core bus layout, op modes and arbiter FSM states.
package trinity_pkg;

    localparam int unsigned BUS_VALID_BIT = 7;
    localparam int unsigned BUS_EXEC_BIT  = 2;
    localparam int unsigned BUS_MODE_LSB  = 0;

    localparam logic [1:0] MODE_ADD  = 2'd0;
    localparam logic [1:0] MODE_MUL3 = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_NOP  = 2'd3;

    localparam logic [7:0] BUS_IDLE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_e;

endpackage

// File: rtl/trinity_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping at NUM_REQ.
module trinity_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int unsigned j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!any_o && (i == j) && req_i[i]) begin
                    any_o    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/trinity_bus_arbiter.sv
// Round-robin arbiter sharing one trinity_core between NUM_REQ requesters.
// Define TRINITY_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.
module trinity_bus_arbiter
    import trinity_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [7:0]             core_bus,
    output logic [7:0]             core_data,
    input  logic [7:0]             core_dout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [7:0]             rsp_data
);

    arb_state_e state_q, state_d;

    logic [ID_W-1:0] rr_ptr_q, id_q;
    logic [7:0]      core_bus_q, core_data_q, rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            rsp_valid_q;

    logic [NUM_REQ-1:0] pick_req, pick_gnt, win_gnt;
    logic [ID_W-1:0]    pick_idx, win_idx, next_ptr;
    logic               pick_any, win_any, ptr_adv;
    logic [1:0]         sel_mode;
    logic [7:0]         sel_data, exec_word;

`ifdef TRINITY_ARB_PRIO_EN
    assign pick_req = req_valid & ~NUM_REQ'(1);
`else
    assign pick_req = req_valid;
`endif

    trinity_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i (pick_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        win_gnt = pick_gnt;
        win_idx = pick_idx;
        win_any = pick_any;
        ptr_adv = 1'b1;
`ifdef TRINITY_ARB_PRIO_EN
        // A priority win leaves the round-robin pointer where it was.
        if (req_valid[0]) begin
            win_gnt = NUM_REQ'(1);
            win_idx = '0;
            win_any = 1'b1;
            ptr_adv = 1'b0;
        end
`endif
    end

    always_comb begin
        sel_mode = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_mode = req_mode[2*i +: 2];
                sel_data = req_data[8*i +: 8];
            end
        end
        exec_word                      = BUS_IDLE;
        exec_word[BUS_VALID_BIT]       = 1'b1;
        exec_word[BUS_EXEC_BIT]        = 1'b1;
        exec_word[BUS_MODE_LSB +: 2]   = sel_mode;
        next_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (win_any) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESPOND;
            ST_RESPOND: if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) ? win_gnt : '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            core_bus_q  <= BUS_IDLE;
            core_data_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_any) begin
                        id_q        <= win_idx;
                        core_bus_q  <= exec_word;
                        core_data_q <= sel_data;
                        if (ptr_adv) rr_ptr_q <= next_ptr;
                    end
                end
                ST_ISSUE: core_bus_q <= BUS_IDLE;
                ST_CAPTURE: begin
                    rsp_data_q  <= core_dout;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                end
                ST_RESPOND: if (rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign core_bus  = core_bus_q;
    assign core_data = core_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_trinity_bus_arbiter.sv
// Directed bench for trinity_bus_arbiter with a behavioural trinity_core accumulator attached.
module tb_trinity_bus_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_mode;
    logic [31:0] req_data;
    logic [7:0]  core_bus;
    logic [7:0]  core_data;
    logic [7:0]  core_dout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    trinity_bus_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .core_bus  (core_bus),
        .core_data (core_data),
        .core_dout (core_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Core model: on an exec word, data_out takes the pre-op accumulator.
    logic [7:0] acc;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc       <= 8'h00;
            core_dout <= 8'h00;
        end else if (core_bus[7] && core_bus[2]) begin
            core_dout <= acc;
            case (core_bus[1:0])
                2'd0:    acc <= acc + core_data;
                2'd1:    acc <= acc + 8'(3 * core_data);
                2'd2:    acc <= acc ^ core_data;
                default: acc <= acc;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] mode, input logic [7:0] data);
        req_mode[2*id +: 2] = mode;
        req_data[8*id +: 8] = data;
        req_valid[id]       = 1'b1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_mode  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        check("rst_core_bus", core_bus, 8'h00);
        check("rst_core_data", core_data, 8'h00);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_req_ready", req_ready, 0);
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        int cnt = 0;
        while (req_ready == 4'b0 && cnt < 20) begin
            @(negedge sys_clk);
            #1;
            cnt++;
        end
        check(tag, (cnt < 20) ? 1 : 0, 1);
    endtask

    task automatic do_op(input int id, input logic [1:0] mode, input logic [7:0] data,
                         input logic [7:0] exp_rsp);
        set_req(id, mode, data);
        #1;
        wait_grant("op_grant_timeout");
        check("op_grant", req_ready, 4'b1 << id);
        @(negedge sys_clk);
        req_valid[id] = 1'b0;
        #1;
        check("issue_bus", core_bus, 8'h84 | {6'b0, mode});
        check("issue_data", core_data, data);
        check("issue_ready", req_ready, 0);
        @(negedge sys_clk);
        #1;
        check("capture_bus", core_bus, 8'h00);
        check("capture_rsp_valid", rsp_valid, 0);
        @(negedge sys_clk);
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_data", rsp_data, exp_rsp);
        @(negedge sys_clk);
        #1;
        check("rsp_dropped", rsp_valid, 0);
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] exp_oh);
        wait_grant({tag, "_timeout"});
        check(tag, req_ready, exp_oh);
        @(negedge sys_clk);
        #1;
        check({tag, "_pulse"}, req_ready, 0);
    endtask

    int rr_exp[6];
    int pr_exp[4];

    initial begin
`ifdef TRINITY_ARB_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0, 0};
        pr_exp = '{0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0, 1};
        pr_exp = '{0, 1, 0, 1};
`endif
        // Basic op sequence through one accumulator.
        do_reset();
        @(negedge sys_clk);
        do_op(0, 2'd0, 8'h05, 8'h00);
        do_op(0, 2'd0, 8'h03, 8'h05);
        do_op(1, 2'd1, 8'h04, 8'h08);
        do_op(2, 2'd2, 8'hFF, 8'h14);
        do_op(3, 2'd3, 8'h7E, 8'hEB);
        do_op(1, 2'd0, 8'h00, 8'hEB);

        // All four requesters held valid.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'd0, 8'h01);
        #1;
        for (int n = 0; n < 6; n++) expect_grant("rr_grant", 4'b1 << rr_exp[n]);
        req_valid = '0;

        // Back-pressure on the response channel.
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, 2'd0, 8'h11);
        #1;
        expect_grant("bp_grant", 4'b0010);
        req_valid[1] = 1'b0;
        set_req(2, 2'd0, 8'h22);
        begin
            int cnt = 0;
            while (!rsp_valid && cnt < 20) begin
                @(negedge sys_clk);
                #1;
                cnt++;
            end
            check("bp_rsp_timeout", (cnt < 20) ? 1 : 0, 1);
        end
        for (int n = 0; n < 10; n++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_data", rsp_data, 8'h00);
            check("bp_ready", req_ready, 0);
            check("bp_bus", core_bus, 8'h00);
            @(negedge sys_clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        #1;
        check("bp_release_valid", rsp_valid, 0);
        check("bp_next_grant", req_ready, 4'b0100);
        req_valid = '0;

        // Reset while the op is in CAPTURE.
        do_reset();
        set_req(0, 2'd0, 8'h20);
        #1;
        check("mid_grant", req_ready, 4'b0001);
        @(negedge sys_clk);
        req_valid[0] = 1'b0;
        @(negedge sys_clk);
        #1;
        check("mid_capture_data", core_data, 8'h20);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_bus", core_bus, 8'h00);
        check("mid_rst_data", core_data, 8'h00);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_rdata", rsp_data, 0);
        check("mid_rst_ready", req_ready, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        do_op(2, 2'd0, 8'h09, 8'h00);
        do_op(2, 2'd0, 8'h01, 8'h09);

        // Requesters 0 and 1 contending.
        do_reset();
        set_req(0, 2'd0, 8'h01);
        set_req(1, 2'd0, 8'h01);
        #1;
        for (int n = 0; n < 4; n++) expect_grant("pr_grant", 4'b1 << pr_exp[n]);
        req_valid[0] = 1'b0;
        expect_grant("pr_after_drop", 4'b0010);
        req_valid = '0;
        repeat (6) @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trinity_bus_arbiter.md
Name: trinity_bus_arbiter

Overview:
- Shares one trinity_core accumulator between NUM_REQ requesters.
- Each requester offers {mode, data} over a valid/ready handshake. The arbiter grants round-robin and drives the core's bus_in/data_in with a one-cycle exec pulse.
- It captures the core's data_out (the accumulator low byte from before the op) and returns it tagged with the requester id over a valid/ready response channel.
- Sits between the tile's requesters and trinity_core; core_bus/core_data/core_dout connect directly to bus_in/data_in/data_out.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- sys_clk  in  1  clock; all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester op request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_mode  in  2*NUM_REQ  flattened mode; requester i at [2i+1:2i].
- req_data  in  8*NUM_REQ  flattened operand; requester i at [8i+7:8i].
- core_bus  out  8  to core bus_in: bit7 valid, bit2 exec, bits1:0 mode, other bits 0.
- core_data  out  8  to core data_in.
- core_dout  in  8  from core data_out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  ID_W  id of the requester the response belongs to.
- rsp_data  out  8  core_dout captured for this op.

Behaviour:
- Reset values (async, with sys_rst_n=0):
  - core_bus=8'h00, core_data=8'h00.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - req_ready=0, state=IDLE, rr_ptr=0.
- State machine has four states: IDLE, ISSUE, CAPTURE, RESPOND.
- IDLE:
  - Select winner g = first i with req_valid[i], searching from rr_ptr upward and wrapping at NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; the transfer happens in that cycle.
  - On the edge, latch id=g, then drive core_bus = 8'h84 | mode_g and core_data = data_g.
  - Set rr_ptr = (g+1) mod NUM_REQ; go to ISSUE.
  - With no request valid: stay in IDLE, keep core_bus=8'h00, leave rr_ptr unchanged.
- ISSUE:
  - Lasts exactly one cycle, during which the core sees the exec word.
  - On the edge, core_bus returns to 8'h00 (core_data may hold its value). Go to CAPTURE.
- CAPTURE:
  - core_dout now holds the pre-op acc[7:0].
  - On the edge: rsp_data <= core_dout, rsp_id <= id, rsp_valid <= 1. Go to RESPOND.
- RESPOND:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On the handshake edge: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in every state except IDLE.
- Latency and throughput:
  - rsp_valid rises 2 cycles after the accept cycle.
  - Minimum spacing is 4 cycles per op when rsp_ready is tied high.
- mode 2'd3 is passed through unchanged. The core holds acc but still updates data_out, so a response is returned as normal.
- Requesters may change or drop req_valid at any time when not granted; no request is lost once accepted.
- Simultaneous requests are resolved only by rr_ptr order. Requester i may be bypassed at most NUM_REQ-1 times.
- Reset mid-operation: the in-flight op and any pending response are discarded. The core shares sys_rst_n, so acc is zeroed consistently.
- No arithmetic is done inside the arbiter. The data path is pure capture/forward at 8 bits.

Optional Feature:
- Macro TRINITY_ARB_PRIO_EN.
- Defined: requester 0 has strict priority. If req_valid[0]=1 in IDLE it wins regardless of rr_ptr, and rr_ptr is not updated. Requesters 1..NUM_REQ-1 arbitrate round-robin among themselves when requester 0 is idle.
- Undefined: pure round-robin over all requesters as described above.

Decomposition:
- Package trinity_pkg holds:
  - bus bit positions: BUS_VALID_BIT=7, BUS_EXEC_BIT=2, BUS_MODE_LSB=0.
  - mode constants: MODE_ADD=2'd0, MODE_MUL3=2'd1, MODE_XOR=2'd2, MODE_NOP=2'd3.
  - BUS_IDLE=8'h00.
  - FSM state encoding.
- One sub-module, trinity_rr_pick: combinational round-robin picker taking (req_valid, rr_ptr) and giving a one-hot grant plus an encoded index. It is reused by other shared tile resources.

Test Plan:
- After reset, req0 sends ADD 5 then ADD 3, rsp_ready=1 -> responses id0 data 0x00, then id0 data 0x05; core_bus pulses 8'h84 for exactly one cycle per op.
- Continue: req1 MUL3 4, req2 XOR 0xFF, req3 mode 3 with data 0x7E -> responses 0x08, then 0x14, then 0xEB (acc left at 0xEB).
- All four requesters hold req_valid=1 from reset -> grant order 0,1,2,3,0,1; each req_ready pulse is one cycle and one-hot.
- rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid/rsp_id/rsp_data stable, req_ready stays 0, core_bus stays 8'h00; release -> next grant follows.
- sys_rst_n asserted during CAPTURE -> all outputs are 0 immediately; after release, a fresh ADD 9 from req2 returns 0x00.
- With TRINITY_ARB_PRIO_EN, req0 and req1 valid continuously -> req0 granted every op and req1 never granted until req0 drops; without the macro, grants alternate 0,1,0,1.
